// File: rtl/bcd_digit_entry.sv
// Keypad digit-entry block: collects one-hot decimal keys into a packed BCD
// number and presents it to a consumer with a valid/ready handshake.
module bcd_digit_entry #(
   parameter int  NUM_DIGITS    = 4,
   parameter int  PRIORITY_HIGH = 1,
   localparam int CNT_W         = $clog2(NUM_DIGITS + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [9:0]              key_in,
   input  logic                    key_valid,
   output logic                    key_ready,
   input  logic                    enter,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [CNT_W-1:0]        digit_cnt,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err,
   output logic                    fsm_state_o
);

   // Handshakes: a key transfers on key_valid & key_ready, the number transfers
   // on out_valid & out_ready; ready/valid are pure decodes of the FSM state.
   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d, bcd_shift;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    err_q, err_d;
   logic [3:0]              digit;
   logic [3:0]              ones;
   logic                    key_ok;
   logic                    key_accept;

   always_comb begin
      digit = 4'd0;
      ones  = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (key_in[i]) begin
            digit = 4'(i);
            ones  = ones + 4'd1;
         end
      end
      key_ok = (ones == 4'd1) || ((ones > 4'd1) && (PRIORITY_HIGH != 0));
   end

   always_comb begin
      bcd_shift      = bcd_q << 4;
      bcd_shift[3:0] = digit;
   end

   assign key_accept = key_valid && (state_q == COLLECT);

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (clear) begin
         state_d = COLLECT;
         bcd_d   = '0;
         cnt_d   = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (key_accept) begin
                  if (!key_ok || (cnt_q == CNT_W'(NUM_DIGITS))) begin
                     err_d = 1'b1;
                  end else begin
                     bcd_d = bcd_shift;
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               // The digit accepted alongside enter is part of the presented number.
               if (enter) begin
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = COLLECT;
                  bcd_d   = '0;
                  cnt_d   = '0;
                  err_d   = 1'b0;
               end
            end
            default: state_d = COLLECT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= COLLECT;
         bcd_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign key_ready   = (state_q == COLLECT);
   assign out_valid   = (state_q == HOLD);
   assign bcd_out     = bcd_q;
   assign digit_cnt   = cnt_q;
   assign err         = err_q;
   assign fsm_state_o = state_q;

endmodule

// File: doc/bcd_digit_entry.md
BCD_DIGIT_ENTRY -- requirements
Module: bcd_digit_entry

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of BCD digits held; legal range 1..8.
REQ-002 Parameter PRIORITY_HIGH, default 1: 1 = multi-hot key resolves to highest set index; 0 = multi-hot key is rejected as an error.
REQ-003 Derived CNT_W = clog2(NUM_DIGITS+1): width of the digit counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 key_in  in  10  decimal one-hot lines; bit i = decimal digit i (D0..D9).
REQ-007 key_valid  in  1  key_in is presented this cycle.
REQ-008 key_ready  out  1  block accepts keys this cycle.
REQ-009 enter  in  1  close the current number and present it.
REQ-010 clear  in  1  synchronous flush of all state.
REQ-011 bcd_out  out  4*NUM_DIGITS  packed BCD value; the least-significant nibble is the newest digit.
REQ-012 digit_cnt  out  CNT_W  number of digits accepted, 0..NUM_DIGITS.
REQ-013 out_valid  out  1  bcd_out holds a completed number.
REQ-014 out_ready  in  1  consumer takes the number when out_valid is high.
REQ-015 err  out  1  sticky error flag.

Function
REQ-016 FSM has exactly two states: COLLECT and HOLD; key_ready = 1 in COLLECT and 0 in HOLD; out_valid = 1 in HOLD and 0 in COLLECT; both flags are decoded from state.
REQ-017 A key is accepted when key_valid & key_ready; key_valid in HOLD is ignored with no error.
REQ-018 Encoding: a single set bit i yields digit i.
REQ-019 Encoding, multi-hot with PRIORITY_HIGH=1: yields the highest set index.
REQ-020 Encoding, multi-hot with PRIORITY_HIGH=0: sets err; no shift, digit_cnt unchanged.
REQ-021 Encoding, zero-hot key_in on an accepted key: sets err; no shift, digit_cnt unchanged.
REQ-022 Valid digit with digit_cnt < NUM_DIGITS: bcd_out shifts left one nibble, the new digit enters the low nibble and digit_cnt increments; visible the cycle after acceptance (latency 1).
REQ-023 Valid digit with digit_cnt == NUM_DIGITS (overflow): key dropped, bcd_out and digit_cnt unchanged, err set.
REQ-024 enter in COLLECT moves to HOLD next cycle, with out_valid=1; enter with digit_cnt=0 is legal and presents value 0.
REQ-025 key and enter accepted in the same cycle: the digit is shifted in and the state moves to HOLD in that same edge; the presented number includes the digit.
REQ-026 enter in HOLD is ignored.
REQ-027 In HOLD, bcd_out, digit_cnt and err are stable while out_ready = 0.
REQ-028 out_valid & out_ready in HOLD moves to COLLECT next cycle with bcd_out=0, digit_cnt=0, err=0.
REQ-029 clear has top priority in any state: next cycle is COLLECT with bcd_out=0, digit_cnt=0 and err=0; a key or enter in the same cycle is discarded.
REQ-030 err stays set until clear, reset or a completed output handshake.
REQ-031 Every output nibble is always in the range 0..9.

Reset
REQ-032 rst_n low forces, immediately and independent of clk: state COLLECT, bcd_out=0, digit_cnt=0, err=0, out_valid=0, key_ready=1.
REQ-033 Reset asserted mid-entry or in HOLD discards the partial or held number.
REQ-034 First key acceptance is possible on the first rising edge after rst_n deasserts.

Verification
REQ-035 N=4: keys 1,2,3 then enter -> bcd_out=16'h0123, digit_cnt=3, out_valid=1 one cycle after enter.
REQ-036 N=4: keys 9,8,7,6,5 -> bcd_out=16'h9876, digit_cnt=4, err=1 after the fifth key.
REQ-037 key_in=10'b0000100100: PRIORITY_HIGH=1 -> digit 5 shifted in. PRIORITY_HIGH=0 -> err=1, no shift. key_in=0 -> err=1, no shift.
REQ-038 HOLD with out_ready=0 for 5 cycles plus key_valid pulses -> outputs stable, key_ready=0. Then out_ready=1 -> next cycle COLLECT, bcd_out=0, digit_cnt=0.
REQ-039 Key 7 and enter in the same cycle after key 4 -> HOLD with bcd_out low byte 8'h47. clear with key -> all zero, key dropped.
REQ-040 rst_n pulsed low between clock edges mid-entry -> outputs zero before the next edge; normal entry resumes afterwards.
